mips_multicycle_ctrl: RTL and testbench

Multicycle sequencer for the 32-bit MIPS core: a Moore finite state machine (FSM) that steps one instruction through fetch, decode, execute, memory and writeback over 3–5 clocks. It replaces the single-cycle decoder when the core shares one unified instruction/data memory and one ALU across cycles. It drives all datapath mux selects, register/memory write enables and the ALU control. It reads only the opcode and funct fields of the instruction register and the ALU zero flag.

---
 rtl/mips_multicycle_ctrl_if.sv | 18 +
 rtl/mips_multicycle_ctrl.sv | 86 ++++++++
 tb/tb_mips_multicycle_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if: instruction fields, zero flag and datapath controls between sequencer and datapath
interface mips_multicycle_ctrl_if;
  logic [5:0] op, funct;
  logic       zero, pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, illegal_op;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;
  modport master (
    input  op, funct, zero,
    output pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
           alusrcb, pcsrc, alucontrol, illegal_op, state
  );
  modport slave (
    output op, funct, zero,
    input  pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
           alusrcb, pcsrc, alucontrol, illegal_op, state
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: Moore sequencer stepping one MIPS instruction through 3-5 clocks
module mips_multicycle_ctrl (
  input logic                    clk,
  input logic                    reset,
  mips_multicycle_ctrl_if.master bus
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
    RTYPEEX = 4'd6, RTYPEWB = 4'd7, BEQEX = 4'd8, ADDIEX = 4'd9, ADDIWB = 4'd10, JEX = 4'd11
  } state_t;
  typedef struct packed {
    logic       pcwrite, branch, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
  } ctl_t;
  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  state_t     state_q, state_d;
  ctl_t       ctl_q, ctl_d;
  logic       op_ok;
  logic [2:0] alu_r;
  assign op_ok = bus.op inside {OP_LW, OP_SW, OP_R, OP_BEQ, OP_ADDI, OP_J};
  assign alu_r = bus.funct == 6'b100010 ? 3'b110 :
                 bus.funct == 6'b100100 ? 3'b000 :
                 bus.funct == 6'b100101 ? 3'b001 :
                 bus.funct == 6'b101010 ? 3'b111 : 3'b010;
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = DECODE;
      DECODE:  state_d = (bus.op == OP_LW || bus.op == OP_SW) ? MEMADR :
                         bus.op == OP_R    ? RTYPEEX :
                         bus.op == OP_BEQ  ? BEQEX :
                         bus.op == OP_ADDI ? ADDIEX :
                         bus.op == OP_J    ? JEX : FETCH;
      MEMADR:  state_d = bus.op == OP_SW ? MEMWR : MEMRD;
      MEMRD:   state_d = MEMWB;
      RTYPEEX: state_d = RTYPEWB;
      ADDIEX:  state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
    if (reset) state_d = FETCH;
  end
  // Controls are decoded from the next state so they leave the flops aligned with state_q
  always_comb begin
    ctl_d = '0;
    ctl_d.alucontrol = 3'b010;
    case (state_d)
      FETCH:   begin ctl_d.irwrite = 1'b1; ctl_d.pcwrite = 1'b1; ctl_d.alusrcb = 2'b01; end
      DECODE:  ctl_d.alusrcb = 2'b11;
      MEMADR:  begin ctl_d.alusrca = 1'b1; ctl_d.alusrcb = 2'b10; end
      MEMRD:   ctl_d.iord = 1'b1;
      MEMWB:   begin ctl_d.regwrite = 1'b1; ctl_d.memtoreg = 1'b1; end
      MEMWR:   begin ctl_d.iord = 1'b1; ctl_d.memwrite = 1'b1; end
      RTYPEEX: ctl_d.alusrca = 1'b1;
      RTYPEWB: begin ctl_d.regwrite = 1'b1; ctl_d.regdst = 1'b1; end
      BEQEX:   begin
        ctl_d.alusrca = 1'b1;
        ctl_d.alucontrol = 3'b110;
        ctl_d.pcsrc = 2'b01;
        ctl_d.branch = 1'b1;
      end
      ADDIEX:  begin ctl_d.alusrca = 1'b1; ctl_d.alusrcb = 2'b10; end
      ADDIWB:  ctl_d.regwrite = 1'b1;
      JEX:     begin ctl_d.pcsrc = 2'b10; ctl_d.pcwrite = 1'b1; end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    state_q <= state_d;
    ctl_q   <= ctl_d;
  end
  assign bus.pcen       = ~reset & (ctl_q.pcwrite | (ctl_q.branch & bus.zero));
  assign bus.irwrite    = ~reset & ctl_q.irwrite;
  assign bus.memwrite   = ~reset & ctl_q.memwrite;
  assign bus.regwrite   = ~reset & ctl_q.regwrite;
  assign bus.iord       = ctl_q.iord;
  assign bus.regdst     = ctl_q.regdst;
  assign bus.memtoreg   = ctl_q.memtoreg;
  assign bus.alusrca    = ctl_q.alusrca;
  assign bus.alusrcb    = ctl_q.alusrcb;
  assign bus.pcsrc      = ctl_q.pcsrc;
  assign bus.alucontrol = state_q == RTYPEEX ? alu_r : ctl_q.alucontrol;
  assign bus.illegal_op = state_q == DECODE && !op_ok;
  assign bus.state      = state_q;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: directed instruction vectors checked against a path-table model every cycle
module tb_mips_multicycle_ctrl;
  logic clk = 0, reset;
  mips_multicycle_ctrl_if bus ();
  mips_multicycle_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  int errors = 0, checks = 0, ms = 0, mw_cnt = 0, rw_cnt = 0;
  bit en = 0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at %0t: got %0d want %0d", n, $time, a, e);
    end
  endtask

  // Next state found by locating the current state in the op's instruction path
  function automatic int nxt(int s, logic [5:0] o);
    int p[$];
    if (s == 0) return 1;
    case (o)
      6'b100011: p = '{0, 1, 2, 3, 4};
      6'b101011: p = '{0, 1, 2, 5};
      6'b000000: p = '{0, 1, 6, 7};
      6'b000100: p = '{0, 1, 8};
      6'b001000: p = '{0, 1, 9, 10};
      6'b000010: p = '{0, 1, 11};
      default:   p = '{0, 1};
    endcase
    for (int i = 0; i < p.size() - 1; i++) if (p[i] == s) return p[i+1];
    return 0;
  endfunction

  function automatic int falu(logic [5:0] f);
    case (f)
      6'b100000: return 2;
      6'b100010: return 6;
      6'b100100: return 0;
      6'b100101: return 1;
      6'b101010: return 7;
      default:   return 2;
    endcase
  endfunction

  always @(posedge clk) ms <= reset ? 0 : nxt(ms, bus.op);

  always @(negedge clk) begin
    if (bus.memwrite === 1'b1) mw_cnt++;
    if (bus.regwrite === 1'b1) rw_cnt++;
    if (en) begin
      bit r, pw;
      bit legal;
      r = reset;
      pw = (ms == 0 || ms == 11);
      legal = bus.op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
      chk("state", bus.state, ms);
      chk("pcen", bus.pcen, !r && (pw || (ms == 8 && bus.zero)));
      chk("iord", bus.iord, ms == 3 || ms == 5);
      chk("memwrite", bus.memwrite, !r && ms == 5);
      chk("irwrite", bus.irwrite, !r && ms == 0);
      chk("regdst", bus.regdst, ms == 7);
      chk("memtoreg", bus.memtoreg, ms == 4);
      chk("regwrite", bus.regwrite, !r && (ms == 4 || ms == 7 || ms == 10));
      chk("alusrca", bus.alusrca, ms == 2 || ms == 6 || ms == 8 || ms == 9);
      chk("alusrcb", bus.alusrcb, ms == 0 ? 1 : ms == 1 ? 3 : (ms == 2 || ms == 9) ? 2 : 0);
      chk("pcsrc", bus.pcsrc, ms == 8 ? 1 : ms == 11 ? 2 : 0);
      chk("alucontrol", bus.alucontrol, ms == 6 ? falu(bus.funct) : ms == 8 ? 6 : 2);
      chk("illegal_op", bus.illegal_op, ms == 1 && !legal);
    end
  end

  typedef struct {
    logic [5:0] op, funct;
    bit tog, zv;
    int cyc;
    int seq[5];
    int alu2, pc_last, mw, rw;
  } vec_t;
  vec_t v[13];

  initial begin
    v[0]  = '{6'b100011, 6'b000000, 1, 0, 5, '{0, 1, 2, 3, 4}, 2, 0, 0, 1};
    v[1]  = '{6'b101011, 6'b000000, 1, 0, 4, '{0, 1, 2, 5, 0}, 2, 0, 1, 0};
    v[2]  = '{6'b000000, 6'b100000, 1, 0, 4, '{0, 1, 6, 7, 0}, 2, 0, 0, 1};
    v[3]  = '{6'b000000, 6'b100010, 1, 0, 4, '{0, 1, 6, 7, 0}, 6, 0, 0, 1};
    v[4]  = '{6'b000000, 6'b100100, 1, 0, 4, '{0, 1, 6, 7, 0}, 0, 0, 0, 1};
    v[5]  = '{6'b000000, 6'b100101, 1, 0, 4, '{0, 1, 6, 7, 0}, 1, 0, 0, 1};
    v[6]  = '{6'b000000, 6'b101010, 1, 0, 4, '{0, 1, 6, 7, 0}, 7, 0, 0, 1};
    v[7]  = '{6'b000000, 6'b111111, 1, 0, 4, '{0, 1, 6, 7, 0}, 2, 0, 0, 1};
    v[8]  = '{6'b000100, 6'b000000, 0, 1, 3, '{0, 1, 8, 0, 0}, 6, 1, 0, 0};
    v[9]  = '{6'b000100, 6'b000000, 0, 0, 3, '{0, 1, 8, 0, 0}, 6, 0, 0, 0};
    v[10] = '{6'b001000, 6'b000000, 1, 0, 4, '{0, 1, 9, 10, 0}, 2, 0, 0, 1};
    v[11] = '{6'b000010, 6'b000000, 1, 0, 3, '{0, 1, 11, 0, 0}, 2, 1, 0, 0};
    v[12] = '{6'b111111, 6'b000000, 1, 0, 2, '{0, 1, 0, 0, 0}, -1, 0, 0, 0};
    reset = 1;
    bus.op = 0;
    bus.funct = 0;
    bus.zero = 0;
    @(posedge clk); #1 en = 1;
    @(negedge clk);
    chk("reset_state", bus.state, 0);
    chk("reset_irwrite", bus.irwrite, 0);
    chk("reset_pcen", bus.pcen, 0);
    @(posedge clk); #1 reset = 0;
    foreach (v[k]) begin
      int mw0, rw0;
      mw0 = mw_cnt;
      rw0 = rw_cnt;
      for (int c = 0; c < v[k].cyc; c++) begin
        bus.op = v[k].op;
        bus.funct = v[k].funct;
        bus.zero = v[k].tog ? c[0] : v[k].zv;
        @(negedge clk);
        chk("state_seq", bus.state, v[k].seq[c]);
        if (c == 0) chk("fetch_irwrite", bus.irwrite, 1);
        if (c == 2 && v[k].alu2 >= 0) chk("alu_lit", bus.alucontrol, v[k].alu2);
        if (c == v[k].cyc - 1) chk("pcen_last", bus.pcen, v[k].pc_last);
        if (v[k].cyc == 2 && c == 1) chk("illegal_lit", bus.illegal_op, 1);
        @(posedge clk); #1;
      end
      chk("memwrite_cycles", mw_cnt - mw0, v[k].mw);
      chk("regwrite_cycles", rw_cnt - rw0, v[k].rw);
    end
    begin
      int mw0;
      mw0 = mw_cnt;
      bus.op = 6'b101011;
      bus.zero = 0;
      @(posedge clk); @(posedge clk); #1 reset = 1;
      @(negedge clk);
      chk("rst_mid_state", bus.state, 2);
      chk("rst_mid_pcen", bus.pcen, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_fetch_state", bus.state, 0);
      chk("rst_fetch_irwrite", bus.irwrite, 0);
      chk("rst_fetch_pcen", bus.pcen, 0);
      @(posedge clk); #1 reset = 0;
      @(negedge clk);
      chk("post_rst_irwrite", bus.irwrite, 1);
      chk("post_rst_pcen", bus.pcen, 1);
      repeat (4) @(posedge clk);
      #1 chk("rst_sw_no_memwrite", mw_cnt - mw0, 1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
